// File: rtl/inst_mem_loader_if.sv
// rtl/inst_mem_loader_if.sv - byte-stream input and instruction-memory write bundle for inst_mem_loader
interface inst_mem_loader_if #(
   parameter int unsigned NBITS = 32
);
   logic [7:0]       i_rx_data;
   logic             i_rx_valid;
   logic             o_inst_mem_wr_en;
   logic [31:0]      o_inst_mem_addr;
   logic [NBITS-1:0] o_inst_mem_data;
   logic             o_cpu_halt;
   logic             o_done;
   logic             o_err;

   modport master (
      input  i_rx_data, i_rx_valid,
      output o_inst_mem_wr_en, o_inst_mem_addr, o_inst_mem_data, o_cpu_halt, o_done, o_err
   );

   modport slave (
      output i_rx_data, i_rx_valid,
      input  o_inst_mem_wr_en, o_inst_mem_addr, o_inst_mem_data, o_cpu_halt, o_done, o_err
   );
endinterface

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - frames an A5/length/words byte stream into instruction-memory writes
// Define LOADER_TIMEOUT_EN to abort a stalled load after TIMEOUT_CYCLES idle cycles.
module inst_mem_loader #(
   parameter int unsigned NBITS          = 32,
   parameter int unsigned MEM_DEPTH      = 256,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   inst_mem_loader_if.master bus
);
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE} state_t;

   state_t           state;
   logic [15:0]      word_cnt;
   logic [15:0]      word_idx;
   logic [1:0]       byte_idx;
   logic [23:0]      shift_q;
   logic             ovf;
   logic [NBITS-1:0] word;
   logic             rx_sync;
   logic             busy;
   logic             in_range;
   logic             last_word;
   logic             timeout;

   assign word      = {shift_q, bus.i_rx_data};
   assign rx_sync   = bus.i_rx_valid && (bus.i_rx_data == SYNC_BYTE);
   assign busy      = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
   assign in_range  = 32'(word_idx) < MEM_DEPTH;
   assign last_word = (word_idx == word_cnt - 16'd1);

`ifdef LOADER_TIMEOUT_EN
   logic [31:0] idle_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || !busy || bus.i_rx_valid)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 32'd1;
   end

   assign timeout = busy && !bus.i_rx_valid && ((idle_cnt + 32'd1) >= TIMEOUT_CYCLES);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state                <= IDLE;
         word_cnt             <= '0;
         word_idx             <= '0;
         byte_idx             <= '0;
         shift_q              <= '0;
         ovf                  <= 1'b0;
         bus.o_inst_mem_wr_en <= 1'b0;
         bus.o_inst_mem_addr  <= '0;
         bus.o_inst_mem_data  <= '0;
         bus.o_cpu_halt       <= 1'b1;
         bus.o_done           <= 1'b0;
         bus.o_err            <= 1'b0;
      end else begin
         bus.o_inst_mem_wr_en <= 1'b0;
         if (timeout) begin
            // Partial word is dropped; halt stays asserted.
            state     <= IDLE;
            bus.o_err <= 1'b1;
         end else if (rx_sync && (state == IDLE || state == DONE)) begin
            state          <= LEN_HI;
            word_idx       <= '0;
            byte_idx       <= '0;
            ovf            <= 1'b0;
            bus.o_cpu_halt <= 1'b1;
            bus.o_done     <= 1'b0;
            bus.o_err      <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               LEN_HI: if (bus.i_rx_valid) begin
                  word_cnt[15:8] <= bus.i_rx_data;
                  state          <= LEN_LO;
               end
               LEN_LO: if (bus.i_rx_valid) begin
                  word_cnt[7:0] <= bus.i_rx_data;
                  if ({word_cnt[15:8], bus.i_rx_data} == 16'd0) begin
                     state          <= DONE;
                     bus.o_done     <= 1'b1;
                     bus.o_cpu_halt <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end
               DATA: if (bus.i_rx_valid) begin
                  shift_q  <= word[23:0];
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     if (in_range) begin
                        bus.o_inst_mem_wr_en <= 1'b1;
                        bus.o_inst_mem_addr  <= {14'd0, word_idx, 2'b00};
                        bus.o_inst_mem_data  <= word;
                     end else begin
                        ovf <= 1'b1;
                     end
                     word_idx <= word_idx + 16'd1;
                     if (last_word)
                        state <= DONE;
                  end
               end
               DONE: begin
                  // Status lands one cycle after the final write strobe.
                  bus.o_done     <= !ovf;
                  bus.o_err      <= ovf;
                  bus.o_cpu_halt <= ovf;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - scoreboard bench for inst_mem_loader (LOADER_TIMEOUT_EN selects timeout checks)
module tb_inst_mem_loader;
   localparam int DEPTH = 2;
   localparam int TO    = 50;
   localparam int EV_WRITE  = 0;
   localparam int EV_STATUS = 1;
   localparam int EV_HALT   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   inst_mem_loader_if #(.NBITS(32)) bus();

   inst_mem_loader #(.NBITS(32), .MEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      int          kind;
      int          cyc;
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;

   ev_t         exp_q[$];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   bit          model_halt = 1'b1;
   logic [31:0] fw [8];

   always @(posedge clk) cyc++;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void push_ev(input int kind, input int c, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.a    = a;
      e.d    = d;
      exp_q.push_back(e);
   endfunction

   task automatic take(input int kind, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_event: got kind %0d a=%h d=%h expected none (cycle %0d)", kind, a, d, cyc);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", 32'(kind), 32'(e.kind));
         chk("event_cycle", 32'(cyc), 32'(e.cyc));
         if (e.kind == EV_WRITE) begin
            chk("wr_addr", a, e.a);
            chk("wr_data", d, e.d);
         end else if (e.kind == EV_STATUS) begin
            chk("status_done_err_halt", a, e.a);
         end
      end
   endtask

   // Monitor: every DUT-visible event pops the scoreboard in order.
   logic prev_done = 1'b0;
   logic prev_err  = 1'b0;
   logic prev_halt = 1'b1;
   always @(negedge clk) begin
      if (bus.o_inst_mem_wr_en === 1'b1)
         take(EV_WRITE, bus.o_inst_mem_addr, bus.o_inst_mem_data);
      if ((bus.o_done === 1'b1 && prev_done === 1'b0) || (bus.o_err === 1'b1 && prev_err === 1'b0))
         take(EV_STATUS, {29'd0, bus.o_done, bus.o_err, bus.o_cpu_halt}, 32'd0);
      if (bus.o_cpu_halt === 1'b1 && prev_halt === 1'b0)
         take(EV_HALT, 32'd0, 32'd0);
      prev_done = bus.o_done;
      prev_err  = bus.o_err;
      prev_halt = bus.o_cpu_halt;
   end

   function automatic int gap(input bit b2b);
      return b2b ? 0 : int'($urandom_range(0, 2));
   endfunction

   task automatic send_byte(input logic [7:0] b, input int g, output int k);
      repeat (g) begin
         @(negedge clk);
         bus.i_rx_valid = 1'b0;
      end
      @(negedge clk);
      bus.i_rx_data  = b;
      bus.i_rx_valid = 1'b1;
      k = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.i_rx_valid = 1'b0;
      end
   endtask

   task automatic send_sync(input bit b2b);
      int k;
      send_byte(8'hA5, gap(b2b), k);
      if (!model_halt)
         push_ev(EV_HALT, k + 1, 32'd0, 32'd0);
      model_halt = 1'b1;
   endtask

   // Reference: words below DEPTH are written at 4*i; status follows the last byte.
   task automatic run_frame(input int n, input bit b2b, input int noise);
      int          k;
      logic [15:0] nn;
      logic [7:0]  b;
      bit          ok;
      nn = 16'(n);
      for (int i = 0; i < noise; i++) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h5A;
         send_byte(b, gap(b2b), k);
      end
      send_sync(b2b);
      send_byte(nn[15:8], gap(b2b), k);
      send_byte(nn[7:0], gap(b2b), k);
      if (n == 0) begin
         push_ev(EV_STATUS, k + 1, 32'd4, 32'd0);
         model_halt = 1'b0;
      end else begin
         for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++)
               send_byte(fw[i][31-8*j -: 8], gap(b2b), k);
            if (i < DEPTH)
               push_ev(EV_WRITE, k + 1, 32'(4 * i), fw[i]);
         end
         ok = (n <= DEPTH);
         push_ev(EV_STATUS, k + 2, ok ? 32'd4 : 32'd3, 32'd0);
         model_halt = !ok;
      end
      idle(3);
   endtask

   task automatic check_reset();
      chk("rst_halt", 32'(bus.o_cpu_halt), 32'd1);
      chk("rst_wr_en", 32'(bus.o_inst_mem_wr_en), 32'd0);
      chk("rst_addr", bus.o_inst_mem_addr, 32'd0);
      chk("rst_data", bus.o_inst_mem_data, 32'd0);
      chk("rst_done", 32'(bus.o_done), 32'd0);
      chk("rst_err", 32'(bus.o_err), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion within 100000 cycles");
      $fatal(1);
   end

   initial begin
      int k;
      int n;
      bus.i_rx_data  = 8'h00;
      bus.i_rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_reset();
      rst = 1'b0;
      model_halt = 1'b1;
      idle(2);

      // Basic load, spaced then back-to-back
      fw[0] = 32'h20080005;
      fw[1] = 32'hAC080000;
      run_frame(2, 1'b0, 0);
      run_frame(2, 1'b1, 0);

      // Noise then empty frame
      send_byte(8'h11, 0, k);
      send_byte(8'hFF, 0, k);
      run_frame(0, 1'b0, 0);

      // Overflow: third word must not be written
      fw[0] = 32'h01020304;
      fw[1] = 32'h05060708;
      fw[2] = 32'h090A0B0C;
      run_frame(3, 1'b0, 0);

      // Reload after overflow, then again after success
      fw[0] = 32'hDEADBEEF;
      run_frame(1, 1'b0, 0);
      run_frame(1, 1'b1, 0);

      // Reset after two data bytes: no write, outputs back to reset values
      send_sync(1'b0);
      send_byte(8'h00, 0, k);
      send_byte(8'h01, 0, k);
      send_byte(8'hDE, 0, k);
      send_byte(8'hAD, 0, k);
      @(negedge clk);
      bus.i_rx_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_reset();
      rst = 1'b0;
      model_halt = 1'b1;
      idle(2);

      // Inter-byte timeout
      send_sync(1'b0);
      send_byte(8'h00, 0, k);
      send_byte(8'h01, 0, k);
      send_byte(8'h12, 0, k);
      send_byte(8'h34, 0, k);
`ifdef LOADER_TIMEOUT_EN
      push_ev(EV_STATUS, k + TO + 1, 32'd3, 32'd0);
      idle(TO + 10);
`else
      idle(1000);
      chk("no_timeout_err", 32'(bus.o_err), 32'd0);
      chk("no_timeout_halt", 32'(bus.o_cpu_halt), 32'd1);
`endif
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_halt = 1'b1;
      idle(2);

      // Randomized frames around the depth boundary
      for (int f = 0; f < 40; f++) begin
         n = int'($urandom_range(0, 4));
         for (int i = 0; i < n; i++)
            fw[i] = $urandom;
         run_frame(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end

      idle(5);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
